// File: rtl/clock_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_ctrl_pkg
//  Description : Shared types and constants for the run-time clock divider
//                controller: default widths, reset configuration, FSM state
//                encoding, the configuration record and its validity check.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_div_ctrl_pkg;

    localparam int C_CNT_W       = 28;  // divisor / high-time counter width
    localparam int C_NUM_W       = 16;  // period-count field width
    localparam int C_DEF_DIVISOR = 2;   // divisor loaded at reset
    localparam int C_DEF_HIGH    = 1;   // high-time loaded at reset

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [C_CNT_W-1:0] divisor;
        logic [C_CNT_W-1:0] high;
        logic [C_NUM_W-1:0] count;   // 0 = free-run
    } cfg_t;

    // A word is usable only if the period has both a high and a low phase.
    function automatic logic cfg_is_valid(input logic [C_CNT_W-1:0] divisor,
                                          input logic [C_CNT_W-1:0] high);
        return (divisor >= C_CNT_W'(2)) && (high != '0) && (high < divisor);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_ctrl_if
//  Description : Configuration handshake between the register block (master)
//                and the clock divider controller (slave).
//  Signals     : cfg_valid   word valid            (master -> slave)
//                cfg_divisor period length         (master -> slave)
//                cfg_high    high cycles / period  (master -> slave)
//                cfg_count   periods per run       (master -> slave)
//                cfg_ready   word can be accepted  (slave  -> master)
//                cfg_err     last word rejected    (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface clock_div_ctrl_if #(
    parameter int CNT_W = 28,
    parameter int NUM_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_divisor;
    logic [CNT_W-1:0] cfg_high;
    logic [NUM_W-1:0] cfg_count;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_divisor, cfg_high, cfg_count,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_divisor, cfg_high, cfg_count,
        output cfg_ready, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clock_div_ctrl_phase.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_phase
//  Description : Phase counter of the divided clock plus the registered
//                clock_out and period_tick outputs.
//  Ports       : clock_in      system clock
//                reset         synchronous active-high reset
//                enable_i      advance the phase this cycle
//                clear_i       force phase and outputs to 0 (wins over enable)
//                divisor_i     period length in clock_in cycles
//                high_i        high cycles per period
//                clock_out_o   divided clock (registered)
//                period_tick_o pulse on the last cycle of each output period
//  Revision    : 1.0  initial release
// ============================================================================
module clock_div_phase
    import clock_div_ctrl_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  wire logic             clock_in,
    input  wire logic             reset,
    input  wire logic             enable_i,
    input  wire logic             clear_i,
    input  wire logic [CNT_W-1:0] divisor_i,
    input  wire logic [CNT_W-1:0] high_i,
    output logic                  clock_out_o,
    output logic                  period_tick_o
);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             w_last;

    always_comb begin
        w_last  = (phase_q == (divisor_i - CNT_W'(1)));
        phase_d = phase_q;
        clk_d   = clk_q;
        tick_d  = tick_q;
        if (clear_i) begin
            phase_d = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
        end else if (enable_i) begin
            clk_d   = (phase_q < high_i);
            tick_d  = w_last;
            phase_d = w_last ? '0 : (phase_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            phase_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clock_out_o   = clk_q;
    assign period_tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_ctrl
//  Description : Run-time programmable divided-clock generator. Accepts a
//                {divisor, high, count} word over a valid/ready handshake and
//                only switches configuration on a period boundary.
//  Ports       : clock_in     system clock
//                reset        synchronous active-high reset
//                cfg          configuration handshake (slave modport)
//                start        begin a run (IDLE only)
//                stop         end the run after the current period
//                clock_out    divided clock, registered
//                period_tick  pulse on the last cycle of each output period
//                busy         run in progress
//                done         pulse when a run ends
//  Revision    : 1.0  initial release
// ============================================================================
module clock_div_ctrl
    import clock_div_ctrl_pkg::*;
#(
    parameter int CNT_W       = C_CNT_W,
    parameter int NUM_W       = C_NUM_W,
    parameter int DEF_DIVISOR = C_DEF_DIVISOR,
    parameter int DEF_HIGH    = C_DEF_HIGH
) (
    input  wire logic       clock_in,
    input  wire logic       reset,
    clock_div_ctrl_if.slave cfg,
    input  wire logic       start,
    input  wire logic       stop,
    output logic            clock_out,
    output logic            period_tick,
    output logic            busy,
    output logic            done
);

    state_t           state_q, state_d;
    cfg_t             act_q, act_d;
    cfg_t             pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             stop_pend_q, stop_pend_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    cfg_t             w_word;
    logic             w_xfer;
    logic             w_word_ok;
    logic             w_start;
    logic             w_bound;
    logic             w_end;

    // The registered tick marks the last cycle of the visible period; the
    // period boundary is the edge that closes that cycle.
    always_comb begin
        w_word      = '{divisor: cfg.cfg_divisor, high: cfg.cfg_high, count: cfg.cfg_count};
        w_xfer      = cfg.cfg_valid & ~pend_vld_q;
        w_word_ok   = cfg_is_valid(cfg.cfg_divisor, cfg.cfg_high);
        w_start     = (state_q == ST_IDLE) && start;
        w_bound     = (state_q == ST_RUN) && period_tick;
        // rem_q is 0 for free-run and never drops below 1 in count mode.
        w_end       = w_bound && (stop_pend_q || (rem_q == NUM_W'(1)));

        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        stop_pend_d = stop_pend_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        err_d       = w_xfer & ~w_word_ok;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d     = ST_RUN;
                    rem_d       = act_q.count;
                    stop_pend_d = 1'b0;
                    // The run starts with the old word; a new one waits.
                    if (w_xfer && w_word_ok) begin
                        pend_d     = w_word;
                        pend_vld_d = 1'b1;
                    end
                end else if (w_xfer && w_word_ok) begin
                    act_d = w_word;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (w_xfer && w_word_ok) begin
                    pend_d     = w_word;
                    pend_vld_d = 1'b1;
                end
                if (w_bound) begin
                    if (pend_vld_q) begin
                        act_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                    if (w_end) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else if (rem_q > NUM_W'(1)) begin
                        rem_d = rem_q - NUM_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            act_q       <= '{divisor: C_CNT_W'(DEF_DIVISOR), high: C_CNT_W'(DEF_HIGH), count: '0};
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            stop_pend_q <= stop_pend_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Phase wrap at the end of the last period is replaced by a clear so the
    // output returns low together with busy.
    clock_div_phase #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clock_in      (clock_in),
        .reset         (reset),
        .enable_i      ((state_q == ST_RUN) && !w_end),
        .clear_i       (w_start || w_end),
        .divisor_i     (act_q.divisor),
        .high_i        (act_q.high),
        .clock_out_o   (clock_out),
        .period_tick_o (period_tick)
    );

    assign busy          = (state_q == ST_RUN);
    assign done          = done_q;
    assign cfg.cfg_ready = ~pend_vld_q;
    assign cfg.cfg_err   = err_q;

endmodule
`default_nettype wire
